// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers,
// with optional bursts of up to MAX_BURST consecutive words per grant.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  localparam int SEL_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  input  logic                     fifo_full,
  output logic [SEL_W-1:0]         fifo_wr_src,
  output logic                     burst_active
);

  // Handshake: a word from requester i moves when req_valid[i] & req_ready[i] on a rising
  // edge; ready never depends on a requester dropping valid, and is low while the FIFO is full.
  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [SEL_W-1:0] owner, owner_nxt;
  logic [7:0]       cnt, cnt_nxt;

  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] cand;
  logic             has_grant;
  logic             xfer;
  logic             last_beat;
  int               idx;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // Grant selection: owner during a burst, else first valid requester from rr_ptr onward.
  always_comb begin
    grant     = '0;
    cand      = '0;
    has_grant = 1'b0;
    idx       = 0;
    if (state == BURST) begin
      grant     = owner;
      has_grant = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = SEL_W'(idx);
        if (!has_grant && req_valid[cand]) begin
          has_grant = 1'b1;
          grant     = cand;
        end
      end
    end
  end

  assign xfer      = has_grant & req_valid[grant] & ~fifo_full & ~rst;
  assign last_beat = (({1'b0, cnt} + 9'd1) == 9'(MAX_BURST));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = has_grant & (grant == SEL_W'(i)) & ~fifo_full & ~rst;
    end
    fifo_wr_en   = xfer;
    fifo_data_in = xfer ? req_data[int'(grant)*WIDTH +: WIDTH] : '0;
    fifo_wr_src  = xfer ? grant : '0;
    burst_active = (state == BURST) & ~rst;
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (MAX_BURST > 1) begin
            state_nxt = BURST;
            owner_nxt = grant;
            cnt_nxt   = 8'd1;
          end else begin
            rr_ptr_nxt = wrap_inc(grant);
          end
        end
      end
      BURST: begin
        // Owner dropping valid costs one dead cycle; a full FIFO simply holds everything.
        if (!req_valid[owner] || (xfer && last_beat)) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          rr_ptr_nxt = wrap_inc(owner);
        end else if (xfer) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
      cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a burst instance (MAX_BURST=4) and a per-word instance
// (MAX_BURST=1) share stimulus; both are compared every cycle against a rule-level model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic            fifo_full = 1'b0;

  logic [NREQ-1:0] rdy_a, rdy_b;
  logic            wr_a, wr_b;
  logic [W-1:0]    din_a, din_b;
  logic [1:0]      src_a, src_b;
  logic            ba_a, ba_b;
  logic [15:0]     obs_a, obs_b;

  int n_vec = 0;
  int n_err = 0;

  assign obs_a = {rdy_a, wr_a, din_a, src_a, ba_a};
  assign obs_b = {rdy_b, wr_b, din_b, src_b, ba_b};

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(NREQ), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy_a), .fifo_wr_en(wr_a), .fifo_data_in(din_a),
    .fifo_full(fifo_full), .fifo_wr_src(src_a), .burst_active(ba_a)
  );

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(NREQ), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy_b), .fifo_wr_en(wr_b), .fifo_data_in(din_b),
    .fifo_full(fifo_full), .fifo_wr_src(src_b), .burst_active(ba_b)
  );

  // Reference model: [0] is the MAX_BURST=4 instance, [1] the MAX_BURST=1 instance.
  int m_burst[2] = '{0, 0};
  int m_owner[2] = '{0, 0};
  int m_cnt[2]   = '{0, 0};
  int m_ptr[2]   = '{0, 0};
  int m_mb[2]    = '{4, 1};

  function automatic int model_grant(input int k);
    if (m_burst[k] != 0) return m_owner[k];
    for (int j = 0; j < NREQ; j++) begin
      int i;
      i = (m_ptr[k] + j) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] model_out(input int k);
    int g;
    bit x;
    logic [3:0] rdy;
    logic [7:0] d;
    logic [1:0] s;
    logic b;
    g = model_grant(k);
    rdy = '0; d = '0; s = '0;
    x = (g >= 0) && !rst && req_valid[g] && !fifo_full;
    if (g >= 0 && !rst && !fifo_full) rdy[g] = 1'b1;
    if (x) begin
      d = req_data[g*W +: W];
      s = 2'(g);
    end
    b = (m_burst[k] != 0) && !rst;
    return {rdy, x, d, s, b};
  endfunction

  task automatic model_commit();
    for (int k = 0; k < 2; k++) begin
      int g;
      bit x;
      g = model_grant(k);
      x = (g >= 0) && !rst && req_valid[g] && !fifo_full;
      if (rst) begin
        m_burst[k] = 0; m_owner[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
      end else if (m_burst[k] == 0) begin
        if (x) begin
          if (m_mb[k] > 1) begin
            m_burst[k] = 1; m_owner[k] = g; m_cnt[k] = 1;
          end else begin
            m_ptr[k] = (g + 1) % NREQ;
          end
        end
      end else if (!req_valid[m_owner[k]] || (x && m_cnt[k] + 1 == m_mb[k])) begin
        m_burst[k] = 0; m_cnt[k] = 0; m_ptr[k] = (m_owner[k] + 1) % NREQ;
      end else if (x) begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
    #1;
    model_commit();
  endtask

  task automatic test_reset();
    logic [15:0] ea, eb;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rst = 1'b1; req_valid = 4'hf; req_data = $urandom; fifo_full = 1'b0;
      #1;
      ea = model_out(0); eb = model_out(1);
      n_vec++;
      if (obs_a !== 16'h0) begin
        n_err++; $display("FAIL reset_outs_a cyc%0d got %h exp 0000", c, obs_a);
      end
      n_vec++;
      if (obs_b !== 16'h0 || obs_b !== eb || obs_a !== ea) begin
        n_err++; $display("FAIL reset_outs_b cyc%0d got %h exp %h", c, obs_b, eb);
      end
      model_commit();
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 4'hf; req_data = $urandom; fifo_full = 1'b0;
    #1;
    n_vec++;
    if ({wr_a, src_a, din_a} !== {1'b1, 2'd0, req_data[7:0]}) begin
      n_err++; $display("FAIL first_grant_a got %h exp %h", {wr_a, src_a, din_a}, {1'b1, 2'd0, req_data[7:0]});
    end
    n_vec++;
    if ({wr_b, src_b, din_b} !== {1'b1, 2'd0, req_data[7:0]}) begin
      n_err++; $display("FAIL first_grant_b got %h exp %h", {wr_b, src_b, din_b}, {1'b1, 2'd0, req_data[7:0]});
    end
    model_commit();
  endtask

  task automatic test_round_robin();
    logic [31:0] a;
    logic [15:0] ea, eb;
    do_reset();
    a = $urandom;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rst = 1'b0; req_valid = 4'hf; req_data = a; fifo_full = 1'b0;
      #1;
      ea = model_out(0); eb = model_out(1);
      n_vec++;
      if ({wr_b, src_b, din_b} !== {1'b1, 2'(c % 4), a[(c%4)*8 +: 8]}) begin
        n_err++; $display("FAIL rr_seq cyc%0d got %h exp %h", c, {wr_b, src_b, din_b}, {1'b1, 2'(c % 4), a[(c%4)*8 +: 8]});
      end
      n_vec++;
      if (obs_a !== ea || obs_b !== eb) begin
        n_err++; $display("FAIL rr_model cyc%0d got %h/%h exp %h/%h", c, obs_a, obs_b, ea, eb);
      end
      model_commit();
    end
  endtask

  task automatic test_burst();
    int src_seq[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
    int ba_seq[9]  = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
    logic [15:0] ea, eb;
    do_reset();
    req_data = $urandom;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rst = 1'b0; req_valid = 4'b0110; fifo_full = 1'b0;
      #1;
      ea = model_out(0); eb = model_out(1);
      n_vec++;
      if ({wr_a, src_a, ba_a} !== {1'b1, 2'(src_seq[c]), 1'(ba_seq[c])}) begin
        n_err++; $display("FAIL burst_seq cyc%0d got %b exp %b", c, {wr_a, src_a, ba_a}, {1'b1, 2'(src_seq[c]), 1'(ba_seq[c])});
      end
      n_vec++;
      if (obs_a !== ea || obs_b !== eb) begin
        n_err++; $display("FAIL burst_model cyc%0d got %h/%h exp %h/%h", c, obs_a, obs_b, ea, eb);
      end
      model_commit();
    end
  endtask

  task automatic test_early_release();
    logic [3:0] v_seq[4] = '{4'b1000, 4'b1000, 4'b0001, 4'b0001};
    int wr_seq[4]  = '{1, 1, 0, 1};
    int src_seq[4] = '{3, 3, 0, 0};
    int ba_seq[4]  = '{0, 1, 1, 0};
    logic [15:0] ea, eb;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rst = 1'b0; req_valid = v_seq[c]; req_data = $urandom; fifo_full = 1'b0;
      #1;
      ea = model_out(0); eb = model_out(1);
      n_vec++;
      if ({wr_a, src_a, ba_a} !== {1'(wr_seq[c]), 2'(src_seq[c]), 1'(ba_seq[c])}) begin
        n_err++; $display("FAIL early_rel cyc%0d got %b exp %b", c, {wr_a, src_a, ba_a}, {1'(wr_seq[c]), 2'(src_seq[c]), 1'(ba_seq[c])});
      end
      n_vec++;
      if (obs_a !== ea || obs_b !== eb) begin
        n_err++; $display("FAIL early_model cyc%0d got %h/%h exp %h/%h", c, obs_a, obs_b, ea, eb);
      end
      model_commit();
    end
  endtask

  task automatic test_full_backpressure();
    logic [15:0] ea, eb;
    logic [3:0] erdy;
    int esrc, ewr, eba;
    do_reset();
    req_data = $urandom;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rst = 1'b0;
      req_valid = (c == 0) ? 4'b0100 : 4'b0110;
      fifo_full = (c >= 1 && c <= 5);
      #1;
      ewr  = fifo_full ? 0 : 1;
      esrc = fifo_full ? 0 : (c == 9 ? 1 : 2);
      eba  = (c >= 1 && c <= 8) ? 1 : 0;
      erdy = fifo_full ? 4'b0000 : (c == 9 ? 4'b0010 : 4'b0100);
      ea = model_out(0); eb = model_out(1);
      n_vec++;
      if ({rdy_a, wr_a, src_a, ba_a} !== {erdy, 1'(ewr), 2'(esrc), 1'(eba)}) begin
        n_err++; $display("FAIL full_bp cyc%0d got %b exp %b", c, {rdy_a, wr_a, src_a, ba_a}, {erdy, 1'(ewr), 2'(esrc), 1'(eba)});
      end
      n_vec++;
      if (obs_a !== ea || obs_b !== eb) begin
        n_err++; $display("FAIL full_model cyc%0d got %h/%h exp %h/%h", c, obs_a, obs_b, ea, eb);
      end
      model_commit();
    end
  endtask

  task automatic test_fifo_integration();
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w, e;
    logic [15:0] ea;
    int sent[3]   = '{0, 0, 0};
    int rd_seq[3] = '{0, 0, 0};
    int waits[3]  = '{0, 0, 0};
    bit pv[3]     = '{0, 0, 0};
    int g, cyc, s;
    do_reset();
    cyc = 0;
    while ((rd_seq[0] + rd_seq[1] + rd_seq[2]) < 48 && cyc < 3000) begin
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && sent[i] < 16 && $urandom_range(0, 3) != 0) pv[i] = 1'b1;
        req_data[i*W +: W] = {2'b00, 2'(i), 4'(sent[i])};
      end
      req_data[3*W +: W] = '0;
      req_valid = {1'b0, pv[2], pv[1], pv[0]};
      fifo_full = (fifo_q.size() == 8);
      #1;
      ea = model_out(0);
      n_vec++;
      if (obs_a !== ea) begin
        n_err++; $display("FAIL integ_model cyc%0d got %h exp %h", cyc, obs_a, ea);
      end
      n_vec++;
      if (wr_a && fifo_q.size() >= 8) begin
        n_err++; $display("FAIL integ_overflow cyc%0d got wr_en=1 exp 0 (fifo full)", cyc);
      end
      if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        w = fifo_q.pop_front();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        s = int'(w[5:4]);
        n_vec++;
        if (w !== e || s > 2 || int'(w[3:0]) != rd_seq[s % 3]) begin
          n_err++; $display("FAIL integ_read cyc%0d got %h exp %h (seq %0d)", cyc, w, e, rd_seq[s % 3]);
        end
        if (s <= 2) rd_seq[s] = rd_seq[s] + 1;
      end
      if (ea[11]) begin
        g = model_grant(0);
        exp_q.push_back(req_data[g*W +: W]);
        for (int i = 0; i < 3; i++) begin
          if (i == g) waits[i] = 0;
          else if (pv[i]) begin
            waits[i] = waits[i] + 1;
            n_vec++;
            if (waits[i] > (NREQ - 1) * 4) begin
              n_err++; $display("FAIL integ_starve req%0d got %0d writes waiting exp <= %0d", i, waits[i], (NREQ - 1) * 4);
            end
          end
        end
        sent[g] = sent[g] + 1;
        pv[g] = 1'b0;
      end
      for (int i = 0; i < 3; i++) if (!pv[i]) waits[i] = 0;
      if (wr_a && fifo_q.size() < 8) fifo_q.push_back(din_a);
      model_commit();
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_seq[i] != 16) begin
        n_err++; $display("FAIL integ_count req%0d got %0d words read exp 16", i, rd_seq[i]);
      end
    end
    n_vec++;
    if (fifo_q.size() != 0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL integ_leftover got %0d/%0d words exp 0/0", fifo_q.size(), exp_q.size());
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_early_release();
    test_full_backpressure();
    test_fifo_integration();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
